uart_periph: RTL

UART_PERIPH -- requirements
Module: uart_periph

---
 rtl/uart_periph.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_periph.sv
// uart_periph -- memory-mapped 8N1 UART for the execute-stage uart window.
//
// Register map (addr[7:0]):
//   0x18 TXD  R/W  write starts a frame when idle; reads last accepted byte
//   0x1C RXD  R    oldest received byte; read pops it
//   0x20 CON  R/W  [0] tx_done [1] rx_valid [2] tx_busy [3] rx_overrun
//                  [4] irq_en  [5] frame_err [7:6] fifo level-1 (FIFO build)
//                  read clears tx_done/rx_overrun/frame_err; write loads irq_en
//
// Ports:
//   clk, reset        clock, async active-low reset
//   um_rd, um_wr      read/write strobes (uart window selected)
//   addr, wdata       byte address / store data
//   um_data           combinational read data
//   rx, tx            serial lines, idle high
//   irq               irq_en & (rx_valid | tx_done)
//
// Build option: define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a
// single holding register.
module uart_periph #(
  parameter int CLK_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        um_rd,
  input  logic        um_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] um_data,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  DIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

  // ---------------------------------------------------------------- decode
  logic w_sel_txd, w_sel_rxd, w_sel_con;
  logic w_txd_wr, w_con_wr, w_rxd_rd, w_con_rd;
  logic w_unused;

  assign w_sel_txd = (addr[7:0] == 8'h18);
  assign w_sel_rxd = (addr[7:0] == 8'h1C);
  assign w_sel_con = (addr[7:0] == 8'h20);
  assign w_txd_wr  = um_wr & w_sel_txd;
  assign w_con_wr  = um_wr & w_sel_con;
  assign w_rxd_rd  = um_rd & w_sel_rxd;
  assign w_con_rd  = um_rd & w_sel_con;
  assign w_unused  = ^{addr[31:8], wdata[31:8]};

  // ---------------------------------------------------------------- TX
  st_t           r_tx_st, w_tx_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_txd;
  logic          r_tx_done;
  logic          w_tx_baud, w_tx_fin, w_tx_load, w_tx_busy;

  assign w_tx_baud = (r_tx_cnt == DIV_M1);
  assign w_tx_busy = (r_tx_st != S_IDLE);

  always_comb begin
    w_tx_nxt     = r_tx_st;
    w_tx_cnt_nxt = r_tx_cnt + 1'b1;
    w_tx_bit_nxt = r_tx_bit;
    w_tx_fin     = 1'b0;
    w_tx_load    = 1'b0;
    case (r_tx_st)
      S_IDLE:  w_tx_cnt_nxt = '0;
      S_START: if (w_tx_baud) begin
                 w_tx_nxt     = S_DATA;
                 w_tx_cnt_nxt = '0;
                 w_tx_bit_nxt = 3'd0;
               end
      S_DATA:  if (w_tx_baud) begin
                 w_tx_cnt_nxt = '0;
                 if (r_tx_bit == 3'd7) w_tx_nxt = S_STOP;
                 else                  w_tx_bit_nxt = r_tx_bit + 3'd1;
               end
      S_STOP:  if (w_tx_baud) begin
                 w_tx_nxt     = S_IDLE;
                 w_tx_cnt_nxt = '0;
                 w_tx_fin     = 1'b1;
               end
      default: w_tx_nxt = S_IDLE;
    endcase
    // A write landing on the stop-completion edge chains straight into a new frame.
    if (w_txd_wr && (r_tx_st == S_IDLE || w_tx_fin)) begin
      w_tx_load    = 1'b1;
      w_tx_nxt     = S_START;
      w_tx_cnt_nxt = '0;
      w_tx_bit_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= 3'd0;
      r_txd    <= 8'h00;
    end else begin
      r_tx_st  <= w_tx_nxt;
      r_tx_cnt <= w_tx_cnt_nxt;
      r_tx_bit <= w_tx_bit_nxt;
      if (w_tx_load) r_txd <= wdata[7:0];
    end
  end

  // Line driven straight from state so reset forces it high without a clock.
  always_comb begin
    case (r_tx_st)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_txd[r_tx_bit];
      default: tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  st_t           r_rx_st, w_rx_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_sh, w_rx_sh_nxt;
  logic          w_rx_baud, w_rx_dlv, w_rx_ferr;

  assign w_rx_baud = (r_rx_cnt == DIV_M1);

  always_comb begin
    w_rx_nxt     = r_rx_st;
    w_rx_cnt_nxt = r_rx_cnt + 1'b1;
    w_rx_bit_nxt = r_rx_bit;
    w_rx_sh_nxt  = r_rx_sh;
    w_rx_dlv     = 1'b0;
    w_rx_ferr    = 1'b0;
    case (r_rx_st)
      S_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_s2) w_rx_nxt = S_START;
      end
      // Half-bit wait puts every later sample mid-bit.
      S_START: if (r_rx_cnt == HALF_M1) begin
                 w_rx_cnt_nxt = '0;
                 w_rx_bit_nxt = 3'd0;
                 w_rx_nxt     = r_rx_s2 ? S_IDLE : S_DATA;
               end
      S_DATA:  if (w_rx_baud) begin
                 w_rx_cnt_nxt = '0;
                 w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
                 if (r_rx_bit == 3'd7) w_rx_nxt = S_STOP;
                 else                  w_rx_bit_nxt = r_rx_bit + 3'd1;
               end
      S_STOP:  if (w_rx_baud) begin
                 w_rx_cnt_nxt = '0;
                 w_rx_nxt     = S_IDLE;
                 w_rx_dlv     = r_rx_s2;
                 w_rx_ferr    = ~r_rx_s2;
               end
      default: w_rx_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= S_IDLE;
      r_rx_cnt  <= '0;
      r_rx_bit  <= 3'd0;
      r_rx_sh   <= 8'h00;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_st   <= w_rx_nxt;
      r_rx_cnt  <= w_rx_cnt_nxt;
      r_rx_bit  <= w_rx_bit_nxt;
      r_rx_sh   <= w_rx_sh_nxt;
    end
  end

  // ---------------------------------------------------------------- RX holding
  logic       w_rx_valid, w_rx_pop, w_ovr_set;
  logic [7:0] w_rxd_byte;
  logic [1:0] w_con_lvl;

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_fcnt;
  logic       w_full, w_push;

  assign w_full     = (r_fcnt == 3'd4);
  assign w_rx_valid = (r_fcnt != 3'd0);
  assign w_rx_pop   = w_rxd_rd & w_rx_valid;
  // Pop frees a slot first, so a full FIFO still takes a byte on a pop edge.
  assign w_push     = w_rx_dlv & (~w_full | w_rx_pop);
  assign w_ovr_set  = w_rx_dlv & w_full & ~w_rx_pop;
  assign w_rxd_byte = r_fifo[r_rp];
  assign w_con_lvl  = w_rx_valid ? 2'(r_fcnt - 3'd1) : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= 8'h00;
      r_wp   <= 2'd0;
      r_rp   <= 2'd0;
      r_fcnt <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= w_rx_sh_nxt;
        r_wp         <= r_wp + 2'd1;
      end
      if (w_rx_pop) r_rp <= r_rp + 2'd1;
      case ({w_push, w_rx_pop})
        2'b10:   r_fcnt <= r_fcnt + 3'd1;
        2'b01:   r_fcnt <= r_fcnt - 3'd1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end
`else
  logic [7:0] r_rxd;
  logic       r_rx_valid;

  assign w_rx_valid = r_rx_valid;
  assign w_rx_pop   = w_rxd_rd & r_rx_valid;
  assign w_ovr_set  = w_rx_dlv & r_rx_valid & ~w_rx_pop;
  assign w_rxd_byte = r_rxd;
  assign w_con_lvl  = 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxd      <= 8'h00;
      r_rx_valid <= 1'b0;
    end else if (w_rx_dlv && (!r_rx_valid || w_rx_pop)) begin
      r_rxd      <= w_rx_sh_nxt;
      r_rx_valid <= 1'b1;
    end else if (w_rx_pop) begin
      r_rx_valid <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------- status
  logic r_ovr, r_ferr, r_irq_en;

  // Set wins over a same-edge CON read so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_done <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (w_tx_fin)       r_tx_done <= 1'b1;
      else if (w_con_rd)  r_tx_done <= 1'b0;
      if (w_ovr_set)      r_ovr     <= 1'b1;
      else if (w_con_rd)  r_ovr     <= 1'b0;
      if (w_rx_ferr)      r_ferr    <= 1'b1;
      else if (w_con_rd)  r_ferr    <= 1'b0;
      if (w_con_wr)       r_irq_en  <= wdata[4];
    end
  end

  assign irq = r_irq_en & (w_rx_valid | r_tx_done);

  always_comb begin
    um_data = 32'h0;
    if (w_sel_txd)      um_data[7:0] = r_txd;
    else if (w_sel_rxd) um_data[7:0] = w_rxd_byte;
    else if (w_sel_con) um_data[7:0] = {w_con_lvl, r_ferr, r_irq_en, r_ovr,
                                        w_tx_busy, w_rx_valid, r_tx_done};
  end

endmodule
